disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl_pkg.sv | 14 +
 rtl/disp_scan_ctrl_if.sv | 22 ++
 rtl/disp_scan_ctrl_prescaler.sv | 32 +++
 rtl/disp_scan_ctrl.sv | 103 ++++++++++
 tb/tb_disp_scan_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
// Digit indices are 2 bits wide and digit enables are active-low.
package disp_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] an_onehot(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bundle between the display scanner and its upstream/downstream neighbours.
// The master drives the value and controls; the slave drives the digit outputs.
interface disp_scan_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  AN;
  logic [3:0]  HEX;
  logic        dp;
  logic        frame_done;

  modport master (
    output en, value, dp_in, blank_lz,
    input  AN, HEX, dp, frame_done
  );

  modport slave (
    input  en, value, dp_in, blank_lz,
    output AN, HEX, dp, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl_prescaler.sv
// Slot-rate prescaler: counts 0..SCAN_DIV-1 while enabled and holds while disabled.
// tick marks the last cycle of each slot.
module scan_prescaler #(
  parameter int SCAN_DIV = 100000,
  parameter int PRE_W    = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (en) begin
      tick  = (pre_q == LAST);
      pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Registered 4-digit display scanner with frame-coherent snapshots,
// leading-zero blanking, enable gating and a frame-start strobe.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int PRE_W    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  disp_scan_if.slave  bus
);

  logic        tick;
  logic        frame_start;
  digit_idx_t  slot;
  logic [15:0] src;
  logic [3:0]  dsrc;
  logic [3:0]  upper_zero;
  logic        blank;
  logic        live;

  digit_idx_t  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0]  dps_q, dps_d;
  logic        shown_q, shown_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_q, dp_d;
  logic        fd_q, fd_d;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .PRE_W    (PRE_W)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .tick  (tick)
  );

  // At a frame start digit 0 is rendered straight from the incoming value
  assign frame_start = tick && (idx_q == 2'd3);
  assign slot        = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;
  assign src         = frame_start ? bus.value : snap_q;
  assign dsrc        = frame_start ? bus.dp_in : dps_q;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = ~|src[4*NUM_DIGITS-1:4*gi];
  end

  assign blank = bus.blank_lz && (slot != 2'd0) && upper_zero[slot];
  // shown_q keeps the display dark between reset release and the first tick
  assign live  = bus.en && (tick || shown_q);

  always_comb begin
    idx_d   = slot;
    snap_d  = frame_start ? bus.value : snap_q;
    dps_d   = frame_start ? bus.dp_in : dps_q;
    shown_d = shown_q | tick;
    an_d    = AN_OFF;
    hex_d   = hex_q;
    dp_d    = 1'b1;
    fd_d    = frame_start;
    if (live) begin
      if (blank) begin
        hex_d = 4'h0;
      end else begin
        an_d  = an_onehot(slot);
        hex_d = src[4*slot +: 4];
        dp_d  = ~dsrc[slot];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd3;
      snap_q  <= 16'h0000;
      dps_q   <= 4'h0;
      shown_q <= 1'b0;
      an_q    <= AN_OFF;
      hex_q   <= 4'h0;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      dps_q   <= dps_d;
      shown_q <= shown_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.HEX        = hex_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=4: every slot is checked
// on each of its four cycles against hand-computed digit outputs.
module tb_disp_scan_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  disp_scan_if bus();

  disp_scan_ctrl #(
    .SCAN_DIV (4),
    .PRE_W    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an, input logic [3:0] hx,
                     input logic d, input logic fd);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {bus.AN, bus.HEX, bus.dp, bus.frame_done};
    exp = {an, hx, d, fd};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed AN=%b HEX=%h dp=%b fd=%b, expected AN=%b HEX=%h dp=%b fd=%b",
             tag, obs[9:6], obs[5:2], obs[1], obs[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // One full slot: four cycles, frame_done only on the first one
  task automatic run_slot(input string tag, input logic [3:0] an, input logic [3:0] hx,
                          input logic d, input logic fd);
    for (int i = 0; i < 4; i++) begin
      step();
      chk(tag, an, hx, d, (i == 0) ? fd : 1'b0);
    end
  endtask

  task automatic first_frame(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_dark"}, 4'b1111, 4'h0, 1'b1, 1'b0);
    end
    run_slot({tag, "_d0"}, 4'b1110, 4'h4, 1'b1, 1'b1);
    run_slot({tag, "_d1"}, 4'b1101, 4'h3, 1'b1, 1'b0);
    run_slot({tag, "_d2"}, 4'b1011, 4'h2, 1'b1, 1'b0);
    run_slot({tag, "_d3"}, 4'b0111, 4'h1, 1'b1, 1'b0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.value    = 16'h1234;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;

    // Reset state and first frame
    step();
    step();
    chk("reset", 4'b1111, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    first_frame("first");

    // Snapshot coherence: value changes while digit 1 is on
    run_slot("coh_d0", 4'b1110, 4'h4, 1'b1, 1'b1);
    run_slot("coh_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    bus.value = 16'hABCD;
    run_slot("coh_d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    run_slot("coh_d3", 4'b0111, 4'h1, 1'b1, 1'b0);
    run_slot("new_d0", 4'b1110, 4'hD, 1'b1, 1'b1);
    run_slot("new_d1", 4'b1101, 4'hC, 1'b1, 1'b0);
    run_slot("new_d2", 4'b1011, 4'hB, 1'b1, 1'b0);
    run_slot("new_d3", 4'b0111, 4'hA, 1'b1, 1'b0);

    // Leading-zero blanking
    bus.value    = 16'h0005;
    bus.blank_lz = 1'b1;
    run_slot("lz5_d0", 4'b1110, 4'h5, 1'b1, 1'b1);
    run_slot("lz5_d1", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_slot("lz5_d2", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_slot("lz5_d3", 4'b1111, 4'h0, 1'b1, 1'b0);
    bus.value = 16'h0000;
    run_slot("lz0_d0", 4'b1110, 4'h0, 1'b1, 1'b1);
    run_slot("lz0_d1", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_slot("lz0_d2", 4'b1111, 4'h0, 1'b1, 1'b0);
    run_slot("lz0_d3", 4'b1111, 4'h0, 1'b1, 1'b0);

    // Decimal point with an inner zero nibble that must stay lit
    bus.value = 16'h0F00;
    bus.dp_in = 4'b0100;
    run_slot("dp_d0", 4'b1110, 4'h0, 1'b1, 1'b1);
    run_slot("dp_d1", 4'b1101, 4'h0, 1'b1, 1'b0);
    run_slot("dp_d2", 4'b1011, 4'hF, 1'b0, 1'b0);
    run_slot("dp_d3", 4'b1111, 4'h0, 1'b1, 1'b0);

    // Enable gating mid-slot
    bus.value    = 16'h1234;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    run_slot("en_d0", 4'b1110, 4'h4, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("en_d1_pre", 4'b1101, 4'h3, 1'b1, 1'b0);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("en_off", 4'b1111, 4'h3, 1'b1, 1'b0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("en_d1_post", 4'b1101, 4'h3, 1'b1, 1'b0);
    end
    run_slot("en_d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    run_slot("en_d3", 4'b0111, 4'h1, 1'b1, 1'b0);

    // Asynchronous reset while digit 2 is shown
    run_slot("ar_d0", 4'b1110, 4'h4, 1'b1, 1'b1);
    run_slot("ar_d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    step();
    chk("ar_d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("ar_async", 4'b1111, 4'h0, 1'b1, 1'b0);
    step();
    step();
    chk("ar_held", 4'b1111, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    first_frame("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
